// File: rtl/load_store_unit.sv
// Memory-access stage of the multicycle RV32I core: one req/ack data-bus transaction per start,
// with byte-lane steering, load extension, alignment/funct3 checks and a bus timeout.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        stage_clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] data_out,
   output logic        save_from_memory,
   output logic        busy,
   output logic        done,
   output logic [1:0]  fault
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    state;
   logic          is_store_q;
   logic [2:0]    funct3_q;
   logic [31:0]   addr_q;
   logic [31:0]   store_data_q;
   logic [CW-1:0] timeout_cnt;

   logic          illegal_f3;
   logic          misaligned;
   logic [1:0]    off;
   logic [3:0]    be_lane;
   logic [31:0]   wdata_lane;
   logic [31:0]   rdata_shifted;
   logic [31:0]   load_ext;

   // Checks run on the raw inputs so the decision is made on the same edge that accepts start.
   always_comb begin
      if (is_store)
         illegal_f3 = (funct3 > 3'b010);
      else
         illegal_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   end

   assign off = addr_q[1:0];

   always_comb begin
      be_lane    = 4'b1111;
      wdata_lane = store_data_q;
      case (funct3_q[1:0])
         2'b00: begin
            be_lane    = 4'b0001 << off;
            wdata_lane = {4{store_data_q[7:0]}};
         end
         2'b01: begin
            be_lane    = 4'b0011 << off;
            wdata_lane = {2{store_data_q[15:0]}};
         end
         default: begin
            be_lane    = 4'b1111;
            wdata_lane = store_data_q;
         end
      endcase
   end

   assign rdata_shifted = mem_rdata >> {off, 3'b000};

   always_comb begin
      load_ext = rdata_shifted;
      case (funct3_q)
         3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b100:  load_ext = {24'd0, rdata_shifted[7:0]};
         3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b101:  load_ext = {16'd0, rdata_shifted[15:0]};
         default: load_ext = rdata_shifted;
      endcase
   end

   // Bus outputs decode straight from state so an async reset drops the request at once.
   assign mem_req          = (state == ST_REQ);
   assign mem_we           = mem_req && is_store_q;
   assign mem_addr         = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be           = mem_req ? be_lane : 4'd0;
   assign mem_wdata        = mem_req ? wdata_lane : 32'd0;
   assign busy             = (state != ST_IDLE);
   assign done             = (state == ST_DONE) || (state == ST_FAULT);
   assign save_from_memory = (state == ST_DONE) && !is_store_q;

   always_ff @(posedge stage_clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         is_store_q   <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= 32'd0;
         store_data_q <= 32'd0;
         timeout_cnt  <= '0;
         fault        <= 2'b00;
         data_out     <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  is_store_q   <= is_store;
                  funct3_q     <= funct3;
                  addr_q       <= addr;
                  store_data_q <= store_data;
                  timeout_cnt  <= '0;
                  if (illegal_f3) begin
                     fault <= 2'b10;
                     state <= ST_FAULT;
                  end else if (misaligned) begin
                     fault <= 2'b01;
                     state <= ST_FAULT;
                  end else begin
                     fault <= 2'b00;
                     state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               // Ack takes priority over a timeout landing on the same edge.
               if (mem_ack) begin
                  state <= ST_DONE;
                  if (!is_store_q)
                     data_out <= load_ext;
               end else if (timeout_cnt == TIMEOUT_LAST) begin
                  fault <= 2'b11;
                  state <= ST_FAULT;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: the stimulus pushes expected completions to a scoreboard
// and an independent monitor pops and compares them whenever done is presented.
module tb_load_store_unit;

   localparam int TIMEOUT = 16;

   logic        stage_clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ack = 1'b0;
   logic [31:0] data_out;
   logic        save_from_memory;
   logic        busy;
   logic        done;
   logic [1:0]  fault;

   typedef struct {
      logic [1:0]  fault;
      logic        save;
      logic [31:0] data;
      int          start_cyc;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] last_load = 32'd0;

   load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .stage_clk(stage_clk), .reset(reset), .start(start), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .data_out(data_out), .save_from_memory(save_from_memory), .busy(busy),
      .done(done), .fault(fault)
   );

   always #5 stage_clk = ~stage_clk;

   always @(posedge stage_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every completion pulse must match the oldest outstanding expectation.
   always @(negedge stage_clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("fault", {30'd0, fault}, {30'd0, e.fault});
            check("save_from_memory", {31'd0, save_from_memory}, {31'd0, e.save});
            check("data_out", data_out, e.data);
            check("done_latency", cyc - e.start_cyc, e.lat);
         end
      end
   end

   task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                                input logic [1:0] exp_fault, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_load);
      exp_t e;
      int   n;
      @(negedge stage_clk);
      start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
      @(posedge stage_clk);
      #1;
      start = 1'b0;
      if (!st && exp_fault == 2'b00) last_load = exp_load;
      e.fault     = exp_fault;
      e.save      = !st && (exp_fault == 2'b00);
      e.data      = last_load;
      e.start_cyc = cyc;
      e.lat       = (exp_fault == 2'b00) ? ack_at : ((exp_fault == 2'b11) ? TIMEOUT : 0);
      sb.push_back(e);
      if (exp_fault == 2'b01 || exp_fault == 2'b10) begin
         @(negedge stage_clk);
         check("no_req_on_fault", {31'd0, mem_req}, 32'd0);
      end else begin
         n = (ack_at == 0) ? TIMEOUT : ack_at;
         for (int i = 1; i <= n; i++) begin
            @(negedge stage_clk);
            check("mem_req", {31'd0, mem_req}, 32'd1);
            check("mem_we", {31'd0, mem_we}, {31'd0, st});
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            check("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
            if (st) check("mem_wdata", mem_wdata, exp_wdata);
            if (i == ack_at) begin
               mem_ack = 1'b1;
               mem_rdata = rd;
            end
         end
         @(posedge stage_clk);
         #1;
         mem_ack = 1'b0;
         mem_rdata = 32'd0;
         @(negedge stage_clk);
         check("req_dropped", {31'd0, mem_req}, 32'd0);
      end
      @(negedge stage_clk);
      check("done_one_cycle", {29'd0, done, save_from_memory, busy}, 32'd0);
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_data_out"}, data_out, 32'd0);
      check({tag, "_done_save"}, {30'd0, done, save_from_memory}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(negedge stage_clk);
      checkOutput("reset");
      check("reset_fault", {30'd0, fault}, 32'd0);
      reset = 1'b0;

      //             st    f3      addr          sd            rdata         ack fault  be       wdata         load
      applyStimulus(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 2'b00, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h8000_0000, 1, 2'b00, 4'b1000, 32'h0,        32'hFFFF_FF80);
      applyStimulus(1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h8000_0000, 3, 2'b00, 4'b1000, 32'h0,        32'h0000_0080);
      applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h7FFF_1234, 1, 2'b00, 4'b1100, 32'h0,        32'h0000_7FFF);
      applyStimulus(1'b1, 3'b001, 32'h0000_0102, 32'hAAAA_5555, 32'h0,        2, 2'b00, 4'b1100, 32'h5555_5555, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0,        32'h0);
      applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 2'b10, 4'b0000, 32'h0,        32'h0);
      applyStimulus(1'b1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, 2'b10, 4'b0000, 32'h0,        32'h0);
      applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h0,        0, 2'b11, 4'b1111, 32'h0,        32'h0);
      applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 16, 2'b00, 4'b1111, 32'h0,       32'h1234_5678);

      // Reset in the middle of a request: bus and result must clear without a write-back.
      @(negedge stage_clk);
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
      @(posedge stage_clk);
      #1;
      start = 1'b0;
      @(negedge stage_clk);
      check("pre_reset_req", {31'd0, mem_req}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset");
      @(negedge stage_clk);
      reset = 1'b0;
      last_load = 32'd0;

      applyStimulus(1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_0000, 1, 2'b00, 4'b1100, 32'h0,        32'h0000_8001);
      applyStimulus(1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_8001, 2, 2'b00, 4'b0011, 32'h0,        32'hFFFF_8001);
      applyStimulus(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,        1, 2'b00, 4'b0010, 32'hA5A5_A5A5, 32'h0);

      repeat (4) @(negedge stage_clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
